// File: rtl/reg_file_pkg.sv
// Shared widths and types for the architectural register file.
// The ROB and dispatcher use the same widths.
package reg_file_pkg;
    localparam int XLEN      = 32;
    localparam int REG_ID_W  = 5;
    localparam int ROB_TAG_W = 4;
    localparam int NUM_REGS  = 1 << REG_ID_W;

    typedef logic [XLEN-1:0]      xlen_t;
    typedef logic [REG_ID_W-1:0]  reg_id_t;
    typedef logic [ROB_TAG_W-1:0] rob_tag_t;
endpackage

// File: rtl/reg_file_read_port.sv
// Combinational operand read with same-cycle commit bypass.
// x0 wins first, then a matching commit, then the stored entry.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int XLEN_P      = XLEN,
    parameter int REG_ID_W_P  = REG_ID_W,
    parameter int ROB_TAG_W_P = ROB_TAG_W
) (
    input  logic [REG_ID_W_P-1:0]                     id,
    input  logic [(1<<REG_ID_W_P)-1:0][XLEN_P-1:0]    val_arr,
    input  logic [(1<<REG_ID_W_P)-1:0]                busy_arr,
    input  logic [(1<<REG_ID_W_P)-1:0][ROB_TAG_W_P-1:0] tag_arr,
    input  logic                                      commit_en,
    input  logic [REG_ID_W_P-1:0]                     commit_rd,
    input  logic [ROB_TAG_W_P-1:0]                    commit_rob_id,
    input  logic [XLEN_P-1:0]                         commit_val,
    output logic [XLEN_P-1:0]                         val,
    output logic                                      busy,
    output logic [ROB_TAG_W_P-1:0]                    tag
);
    logic bypass_hit;

    assign bypass_hit = commit_en && (commit_rd == id) && busy_arr[id]
                        && (tag_arr[id] == commit_rob_id);

    always_comb begin
        val  = val_arr[id];
        busy = busy_arr[id];
        tag  = tag_arr[id];
        if (id == '0) begin
            val  = '0;
            busy = 1'b0;
            tag  = '0;
        end else if (bypass_hit) begin
            val  = commit_val;
            busy = 1'b0;
        end
    end
endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register busy bit and ROB producer tag.
// Commits retire values, issues rename destinations, clear drops every rename.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN_P      = XLEN,
    parameter int REG_ID_W_P  = REG_ID_W,
    parameter int ROB_TAG_W_P = ROB_TAG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   clear,
    input  logic                   commit_en,
    input  logic [REG_ID_W_P-1:0]  commit_rd,
    input  logic [ROB_TAG_W_P-1:0] commit_rob_id,
    input  logic [XLEN_P-1:0]      commit_val,
    input  logic                   issue_en,
    input  logic [REG_ID_W_P-1:0]  issue_rd,
    input  logic [ROB_TAG_W_P-1:0] issue_rob_id,
    input  logic [REG_ID_W_P-1:0]  rs1_id,
    input  logic [REG_ID_W_P-1:0]  rs2_id,
    output logic [XLEN_P-1:0]      rs1_val,
    output logic [XLEN_P-1:0]      rs2_val,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic [ROB_TAG_W_P-1:0] rs1_tag,
    output logic [ROB_TAG_W_P-1:0] rs2_tag
);
    localparam int NREGS = 1 << REG_ID_W_P;

    logic [NREGS-1:0][XLEN_P-1:0]      val_q,  val_d;
    logic [NREGS-1:0]                  busy_q, busy_d;
    logic [NREGS-1:0][ROB_TAG_W_P-1:0] tag_q,  tag_d;

    logic commit_act;
    logic issue_act;

    assign commit_act = rdy && commit_en && (commit_rd != '0);
    assign issue_act  = rdy && issue_en && (issue_rd != '0);

    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commit_act) begin
            val_d[commit_rd] = commit_val;
            // Only the youngest producer may release the register.
            if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_id)) begin
                busy_d[commit_rd] = 1'b0;
            end
        end
        if (rdy && clear) begin
            busy_d = '0;
        end else if (issue_act) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_rob_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q  <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    reg_file_read_port #(
        .XLEN_P      (XLEN_P),
        .REG_ID_W_P  (REG_ID_W_P),
        .ROB_TAG_W_P (ROB_TAG_W_P)
    ) u_rd1 (
        .id            (rs1_id),
        .val_arr       (val_q),
        .busy_arr      (busy_q),
        .tag_arr       (tag_q),
        .commit_en     (commit_en),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .val           (rs1_val),
        .busy          (rs1_busy),
        .tag           (rs1_tag)
    );

    reg_file_read_port #(
        .XLEN_P      (XLEN_P),
        .REG_ID_W_P  (REG_ID_W_P),
        .ROB_TAG_W_P (ROB_TAG_W_P)
    ) u_rd2 (
        .id            (rs2_id),
        .val_arr       (val_q),
        .busy_arr      (busy_q),
        .tag_arr       (tag_q),
        .commit_en     (commit_en),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .val           (rs2_val),
        .busy          (rs2_busy),
        .tag           (rs2_tag)
    );
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read results,
// a monitor pops and compares them on the falling edge.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_rob_id;
    logic [31:0] commit_val;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_rob_id;
    logic [4:0]  rs1_id, rs2_id;
    logic [31:0] rs1_val, rs2_val;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;

    int checks = 0;
    int errors = 0;

    reg_file dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .clear         (clear),
        .commit_en     (commit_en),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .issue_en      (issue_en),
        .issue_rd      (issue_rd),
        .issue_rob_id  (issue_rob_id),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_tag       (rs1_tag),
        .rs2_tag       (rs2_tag)
    );

    always #5 clk = ~clk;

    // Reference model: architectural value plus "who owns this register".
    logic [31:0] m_val   [32];
    bit          m_owned [32];
    logic [3:0]  m_owner [32];

    typedef struct {
        string       name;
        logic [4:0]  id1, id2;
        logic [31:0] v1, v2;
        bit          b1, b2;
        logic [3:0]  t1, t2;
    } exp_t;
    exp_t sb[$];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 0; m_owned[i] = 0; m_owner[i] = 0;
        end
    endtask

    // What the dispatcher should see for a source register right now.
    task automatic model_read(input logic [4:0] id, output logic [31:0] v,
                              output bit b, output logic [3:0] t);
        v = m_val[id]; b = m_owned[id]; t = m_owner[id];
        if (id == 0) begin
            v = 0; b = 0; t = 0;
        end else if (commit_en && commit_rd == id && m_owned[id] && m_owner[id] == commit_rob_id) begin
            v = commit_val; b = 0;
        end
    endtask

    task automatic model_edge();
        bit drop_owner;
        if (!rdy) return;
        drop_owner = commit_en && commit_rd != 0 && m_owned[commit_rd] && m_owner[commit_rd] == commit_rob_id;
        if (commit_en && commit_rd != 0) m_val[commit_rd] = commit_val;
        if (drop_owner) m_owned[commit_rd] = 0;
        if (clear) begin
            for (int i = 0; i < 32; i++) m_owned[i] = 0;
        end else if (issue_en && issue_rd != 0) begin
            m_owned[issue_rd] = 1;
            m_owner[issue_rd] = issue_rob_id;
        end
    endtask

    task automatic push(input string name);
        exp_t e;
        e.name = name; e.id1 = rs1_id; e.id2 = rs2_id;
        model_read(rs1_id, e.v1, e.b1, e.t1);
        model_read(rs2_id, e.v2, e.b2, e.t2);
        sb.push_back(e);
    endtask

    task automatic step(input string name, input bit r, input bit cl,
                        input bit ce, input logic [4:0] crd, input logic [3:0] cid, input logic [31:0] cv,
                        input bit ie, input logic [4:0] ird, input logic [3:0] iid,
                        input logic [4:0] a, input logic [4:0] b);
        @(posedge clk); #1;
        rdy = r; clear = cl;
        commit_en = ce; commit_rd = crd; commit_rob_id = cid; commit_val = cv;
        issue_en = ie; issue_rd = ird; issue_rob_id = iid;
        rs1_id = a; rs2_id = b;
        push(name);
        model_edge();
    endtask

    task automatic idle_read(input string name, input logic [4:0] a, input logic [4:0] b);
        step(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, a, b);
    endtask

    task automatic cmp_port(input string name, input int port, input logic [4:0] id,
                            input logic [31:0] av, input logic ab, input logic [3:0] at,
                            input logic [31:0] ev, input bit eb, input logic [3:0] et);
        checks++;
        if (ab !== eb) begin
            errors++;
            $display("FAIL %s rs%0d x%0d busy got %0b expected %0b", name, port, id, ab, eb);
        end
        checks++;
        if (av !== ev) begin
            errors++;
            $display("FAIL %s rs%0d x%0d val got %h expected %h", name, port, id, av, ev);
        end
        if (eb) begin
            checks++;
            if (at !== et) begin
                errors++;
                $display("FAIL %s rs%0d x%0d tag got %0d expected %0d", name, port, id, at, et);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp_port(e.name, 1, e.id1, rs1_val, rs1_busy, rs1_tag, e.v1, e.b1, e.t1);
                cmp_port(e.name, 2, e.id2, rs2_val, rs2_busy, rs2_tag, e.v2, e.b2, e.t2);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [4:0] r;
        rst = 1; rdy = 0; clear = 0;
        commit_en = 0; commit_rd = 0; commit_rob_id = 0; commit_val = 0;
        issue_en = 0; issue_rd = 0; issue_rob_id = 0;
        rs1_id = 5'd5; rs2_id = 5'd31;
        model_reset();
        #2;
        push("reset_state");
        @(posedge clk); #1;
        rst = 0;

        step("x0_write", 1, 0, 1, 0, 0, 32'hDEAD, 1, 0, 3, 0, 0);
        idle_read("x0_after", 0, 0);

        step("rename_x5", 1, 0, 0, 0, 0, 0, 1, 5, 2, 5, 0);
        idle_read("x5_busy", 5, 0);
        step("x5_bypass", 1, 0, 1, 5, 2, 32'h1234, 0, 0, 0, 5, 5);
        idle_read("x5_stored", 5, 0);

        step("x7_t1", 1, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0);
        step("x7_t4", 1, 0, 0, 0, 0, 0, 1, 7, 4, 0, 0);
        step("x7_stale", 1, 0, 1, 7, 1, 32'h55, 0, 0, 0, 7, 0);
        idle_read("x7_still_busy", 7, 7);

        step("x9_t6", 1, 0, 0, 0, 0, 0, 1, 9, 6, 0, 0);
        step("x9_cmt_iss", 1, 0, 1, 9, 6, 32'h99, 1, 9, 8, 9, 0);
        idle_read("x9_reissued", 9, 0);

        step("x3_t5", 1, 0, 0, 0, 0, 0, 1, 3, 5, 0, 0);
        step("x4_t6", 1, 0, 0, 0, 0, 0, 1, 4, 6, 0, 0);
        step("clear", 1, 1, 1, 3, 5, 32'h77, 1, 10, 9, 3, 4);
        idle_read("after_clear", 3, 4);
        idle_read("after_clear_x10", 10, 3);

        step("rdy_low", 0, 0, 0, 0, 0, 0, 1, 2, 1, 2, 0);
        idle_read("rdy_low_after", 2, 0);

        step("x12_t3", 1, 0, 1, 20, 0, 32'hABCD, 1, 12, 3, 0, 0);
        idle_read("x12_busy", 12, 20);
        @(posedge clk); #1;
        rdy = 1; clear = 0; commit_en = 0; issue_en = 0;
        rs1_id = 12; rs2_id = 20;
        #2;
        rst = 1;
        model_reset();
        push("async_reset");
        @(posedge clk); #1;
        rst = 0;
        idle_read("post_reset", 12, 20);

        for (int n = 0; n < 1500; n++) begin
            r = 5'($urandom_range(0, 7));
            step("random",
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 1) == 1),
                 r,
                 (m_owned[r] && $urandom_range(0, 3) != 0) ? m_owner[r] : 4'($urandom),
                 $urandom,
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 7)),
                 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? r : 5'($urandom_range(0, 7)));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
